// File: rtl/conv2_pkg.sv
// Shared widths for the conv layer-2 processing elements.
package conv2_pkg;

    localparam int IFMAP_W = 8;
    localparam int WGT_W   = 8;
    localparam int PSUM_W  = 20;
    localparam int TAPS    = 3;
    localparam int PROD_W  = IFMAP_W + WGT_W;

endpackage

// File: rtl/pe_conv2_tapline.sv
// TAPS-deep feature-map shift register; taps[0] is the newest sample.
module pe_conv2_tapline #(
    parameter int W     = 8,
    parameter int DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [W-1:0]             din,
    output logic [DEPTH-1:0][W-1:0]  taps
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/pe_conv2_mac3.sv
// Three-tap MAC processing element: psum_out <= psum_in + sum(tap_i * w_i), wrapping.
module pe_conv2_mac3
    import conv2_pkg::*;
#(
    parameter int IFMAP_W = conv2_pkg::IFMAP_W,
    parameter int WGT_W   = conv2_pkg::WGT_W,
    parameter int PSUM_W  = conv2_pkg::PSUM_W,
    parameter int TAPS    = conv2_pkg::TAPS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [TAPS*WGT_W-1:0]    filtr_in,
    input  logic [IFMAP_W-1:0]       ifmap_shift_in,
    input  logic [PSUM_W-1:0]        psum_in,
    output logic [TAPS*WGT_W-1:0]    filtr_out,
    output logic [IFMAP_W-1:0]       ifmap_shift_out,
    output logic [PSUM_W-1:0]        psum_out
);

    localparam int MUL_W = IFMAP_W + WGT_W;

    logic [TAPS-1:0][IFMAP_W-1:0] taps;
    logic signed [MUL_W-1:0]      prod [TAPS];
    logic signed [PSUM_W-1:0]     sum;

    pe_conv2_tapline #(
        .W     (IFMAP_W),
        .DEPTH (TAPS)
    ) u_tapline (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (ifmap_shift_in),
        .taps  (taps)
    );

    assign ifmap_shift_out = taps[0];

    // Products come from the pre-edge taps, so tap0 is the sample from the previous enabled edge.
    always_comb begin
        sum = $signed(psum_in);
        for (int unsigned i = 0; i < TAPS; i++) begin
            prod[i] = $signed(taps[i]) * $signed(filtr_in[i*WGT_W +: WGT_W]);
            sum     = sum + PSUM_W'(prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psum_out  <= '0;
            filtr_out <= '0;
        end else if (en) begin
            psum_out  <= sum;
            filtr_out <= filtr_in;
        end
    end

endmodule

// File: tb/tb_pe_conv2_mac3.sv
// Self-checking bench for pe_conv2_mac3: directed vector table plus randomized run against a reference model.
module tb_pe_conv2_mac3;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] filtr_in;
    logic [7:0]  ifmap_shift_in;
    logic [19:0] psum_in;
    logic [23:0] filtr_out;
    logic [7:0]  ifmap_shift_out;
    logic [19:0] psum_out;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: last three accepted samples (index 0 newest) and expected outputs
    int          hist [3];
    logic [19:0] m_psum;
    logic [23:0] m_filt;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [7:0]  ifm;
        logic [23:0] filt;
        logic [19:0] psum;
        logic [19:0] exp_psum;
        logic [23:0] exp_filt;
        logic [7:0]  exp_ifm;
    } vec_t;

    vec_t vecs [$];

    pe_conv2_mac3 #(
        .IFMAP_W (8),
        .WGT_W   (8),
        .PSUM_W  (20),
        .TAPS    (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .filtr_in        (filtr_in),
        .ifmap_shift_in  (ifmap_shift_in),
        .psum_in         (psum_in),
        .filtr_out       (filtr_out),
        .ifmap_shift_out (ifmap_shift_out),
        .psum_out        (psum_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: plain signed integer arithmetic, result reduced modulo 2^20.
    task automatic model_edge();
        int acc;
        if (!rst_n) begin
            hist   = '{0, 0, 0};
            m_psum = '0;
            m_filt = '0;
        end else if (en) begin
            acc = int'($signed(psum_in));
            for (int k = 0; k < 3; k++) begin
                logic [7:0] wb;
                wb = filtr_in[8*k +: 8];
                acc += hist[k] * int'($signed(wb));
            end
            m_psum  = acc[19:0];
            m_filt  = filtr_in;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = int'($signed(ifmap_shift_in));
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [7:0] ifm,
                         input logic [23:0] f, input logic [19:0] p);
        rst_n          = r;
        en             = e;
        ifmap_shift_in = ifm;
        filtr_in       = f;
        psum_in        = p;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] ifm,
                                input logic [23:0] f, input logic [19:0] p,
                                input logic [19:0] ep, input logic [23:0] ef, input logic [7:0] ei);
        vec_t v;
        v.rst_n = r; v.en = e; v.ifm = ifm; v.filt = f; v.psum = p;
        v.exp_psum = ep; v.exp_filt = ef; v.exp_ifm = ei;
        return v;
    endfunction

    initial begin
        logic [7:0] last_ifm;
        rst_n = 1'b0; en = 1'b1; filtr_in = '0; ifmap_shift_in = '0; psum_in = '0;
        hist = '{0, 0, 0}; m_psum = '0; m_filt = '0;

        // reset with nonzero inputs, then release
        vecs.push_back(mk(0, 1, 8'h09, 24'h123456, 20'd100, 20'h0, 24'h0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h09, 24'h123456, 20'd100, 20'h0, 24'h0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h05, 24'h0A0B0C, 20'd7,   20'd7, 24'h0A0B0C, 8'h05));
        // reset wins over en=0
        vecs.push_back(mk(0, 0, 8'h11, 24'h111111, 20'd9,   20'h0, 24'h0, 8'h00));
        // shift and MAC
        vecs.push_back(mk(1, 1, 8'd1, 24'h010101, 20'd10, 20'd10, 24'h010101, 8'd1));
        vecs.push_back(mk(1, 1, 8'd2, 24'h010101, 20'd10, 20'd11, 24'h010101, 8'd2));
        vecs.push_back(mk(1, 1, 8'd3, 24'h010101, 20'd10, 20'd13, 24'h010101, 8'd3));
        vecs.push_back(mk(1, 1, 8'd0, 24'h010101, 20'd10, 20'd16, 24'h010101, 8'd0));
        // signed math
        vecs.push_back(mk(1, 1, 8'h00, 24'h000000, 20'd0, 20'h0, 24'h0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h00, 24'h000000, 20'd0, 20'h0, 24'h0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h80, 24'h000000, 20'd0, 20'h0, 24'h0, 8'h80));
        vecs.push_back(mk(1, 1, 8'h7F, 24'h000080, 20'd0, 20'h04000, 24'h000080, 8'h7F));
        vecs.push_back(mk(1, 1, 8'h00, 24'h000080, 20'd0, 20'hFC080, 24'h000080, 8'h00));
        // wrap-around
        vecs.push_back(mk(1, 1, 8'h01, 24'h000001, 20'd0,      20'h0,     24'h000001, 8'h01));
        vecs.push_back(mk(1, 1, 8'h00, 24'h000001, 20'h7FFFF,  20'h80000, 24'h000001, 8'h00));
        // enable hold, then held taps {0,1,0} used
        vecs.push_back(mk(1, 0, 8'h55, 24'hABCDEF, 20'd12345, 20'h80000, 24'h000001, 8'h00));
        vecs.push_back(mk(1, 0, 8'hAA, 24'h123456, 20'd777,   20'h80000, 24'h000001, 8'h00));
        vecs.push_back(mk(1, 0, 8'h3C, 24'hFFFFFF, 20'hFFFFF, 20'h80000, 24'h000001, 8'h00));
        vecs.push_back(mk(1, 1, 8'h04, 24'h020202, 20'd0,     20'd2,     24'h020202, 8'h04));
        // mid-run reset
        vecs.push_back(mk(1, 1, 8'h06, 24'h020202, 20'd1,  20'd11, 24'h020202, 8'h06));
        vecs.push_back(mk(0, 1, 8'h07, 24'h020202, 20'd1,  20'h0,  24'h0,      8'h00));
        vecs.push_back(mk(1, 1, 8'h03, 24'h010203, 20'd50, 20'd50, 24'h010203, 8'h03));
        vecs.push_back(mk(1, 1, 8'h09, 24'h010203, 20'd50, 20'd59, 24'h010203, 8'h09));

        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].ifm, vecs[i].filt, vecs[i].psum);
            check($sformatf("vec%0d psum_out", i), 32'(psum_out), 32'(vecs[i].exp_psum));
            check($sformatf("vec%0d filtr_out", i), 32'(filtr_out), 32'(vecs[i].exp_filt));
            check($sformatf("vec%0d ifmap_shift_out", i), 32'(ifmap_shift_out), 32'(vecs[i].exp_ifm));
        end

        // randomized run against the reference model
        drive(0, 1, 8'h00, 24'h0, 20'h0);
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 24'($urandom), 20'($urandom));
            last_ifm = 8'(hist[0]);
            check($sformatf("rnd%0d psum_out", n), 32'(psum_out), 32'(m_psum));
            check($sformatf("rnd%0d filtr_out", n), 32'(filtr_out), 32'(m_filt));
            check($sformatf("rnd%0d ifmap_shift_out", n), 32'(ifmap_shift_out), 32'(last_ifm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
